// File: rtl/ws2811_encoder.sv
// WS2811/WS2812 single-wire NRZ serialiser with a one-pixel holding buffer and end-of-frame latch.
// Optional feature macro: WS2811_INVERT_EN (drives dout inverted for inverting level shifters).
module ws2811_encoder #(
  parameter int unsigned T0H_CYCLES   = 20,
  parameter int unsigned T1H_CYCLES   = 40,
  parameter int unsigned BIT_CYCLES   = 62,
  parameter int unsigned LATCH_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_data,
  input  logic        pix_last,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        underrun
);

`ifdef WS2811_INVERT_EN
  localparam logic IDLE_LEVEL = 1'b1;
`else
  localparam logic IDLE_LEVEL = 1'b0;
`endif

  localparam int unsigned MAX_CYCLES = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES);

  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_param_check
    $error("ws2811_encoder: require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_WAIT,
    S_LATCH
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [CW-1:0]   hi_end;
  logic [4:0]      bit_idx;
  logic [4:0]      bit_next;
  logic [23:0]     shift;
  logic [23:0]     shift_next;
  logic            cur_last;
  logic            last_next;
  logic [23:0]     hold_data;
  logic            hold_last;
  logic            hold_valid;
  logic            load;
  logic            accept;
  logic            dout_next;
  logic            underrun_next;

  assign pix_ready = ~hold_valid;
  assign accept    = pix_valid & ~hold_valid;
  assign hi_end    = shift[23] ? CW'(T1H_CYCLES - 1) : CW'(T0H_CYCLES - 1);

  // Holding register; a load empties it, an accept refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
    end else begin
      if (load) begin
        hold_valid <= 1'b0;
      end
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= pix_data;
        hold_last  <= pix_last;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      cur_last <= 1'b0;
      dout     <= IDLE_LEVEL;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      cur_last <= last_next;
      dout     <= dout_next ^ IDLE_LEVEL;
      busy     <= (state != S_IDLE);
      underrun <= underrun_next;
    end
  end

  // Next-state logic; the cycle counter spans HIGH+LOW of one bit, then is reused for the latch.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bit_next      = bit_idx;
    shift_next    = shift;
    last_next     = cur_last;
    load          = 1'b0;
    dout_next     = 1'b0;
    underrun_next = 1'b0;

    case (state)
      S_IDLE: begin
        if (hold_valid) begin
          load       = 1'b1;
          state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        dout_next = 1'b1;
        cnt_next  = cnt + CW'(1);
        if (cnt == hi_end) begin
          state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt == CW'(BIT_CYCLES - 1)) begin
          cnt_next = '0;
          if (bit_idx != 5'd0) begin
            bit_next   = bit_idx - 5'd1;
            shift_next = {shift[22:0], 1'b0};
            state_next = S_HIGH;
          end else if (cur_last) begin
            state_next = S_LATCH;
          end else if (hold_valid) begin
            load       = 1'b1;
            state_next = S_HIGH;
          end else begin
            underrun_next = 1'b1;
            state_next    = S_WAIT;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (hold_valid) begin
          load       = 1'b1;
          state_next = S_HIGH;
        end
      end
      S_LATCH: begin
        if (cnt == CW'(LATCH_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (load) begin
      shift_next = hold_data;
      last_next  = hold_last;
      bit_next   = 5'd23;
      cnt_next   = '0;
    end
  end

endmodule

// File: tb/tb_ws2811_encoder.sv
// Self-checking bench for ws2811_encoder: a dout decoder feeds a scoreboard of accepted pixels,
// plus a vector table of single-pixel frames and hand-written multi-cycle sequences.
module tb_ws2811_encoder;

  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int BIT   = 62;
  localparam int LATCH = 2500;
  localparam int FRAME = 24 * BIT;

`ifdef WS2811_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        pix_valid;
  logic        pix_ready;
  logic        dout;
  logic        busy;
  logic        underrun;
  logic        dl;

  always #5 clk = ~clk;

  assign dl = dout ^ INV;

  ws2811_encoder #(
    .T0H_CYCLES  (T0H),
    .T1H_CYCLES  (T1H),
    .BIT_CYCLES  (BIT),
    .LATCH_CYCLES(LATCH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_data (pix_data),
    .pix_last (pix_last),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .dout     (dout),
    .busy     (busy),
    .underrun (underrun)
  );

  typedef struct {
    logic [23:0] data;
    int          first_hi;
  } vec_t;

  vec_t        vecs[4];
  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          rises_tot  = 0;
  int          normal_tot = 0;
  int          und_cnt    = 0;
  int          odd_lo     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decodes dout into bits and words; counts rises, 62-cycle periods and underrun cycles.
  task automatic monitor();
    logic        prev   = 1'b0;
    logic        have   = 1'b0;
    int          hi     = 0;
    int          lo     = 0;
    int          lasthi = 0;
    int          nb     = 0;
    logic [23:0] sh     = '0;
    logic [23:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0; have = 1'b0; hi = 0; lo = 0; nb = 0;
        continue;
      end
      if (underrun) und_cnt++;
      if (dl) begin
        if (!prev) begin
          rises_tot++;
          if (have && (lasthi + lo == BIT)) normal_tot++;
          else if (have) odd_lo = lo;
          have = 1'b1;
          lo   = 0;
          hi   = 0;
        end
        hi++;
      end else begin
        if (prev) begin
          check("bit_high_width", 32'((hi == T0H) || (hi == T1H)), 32'd1);
          sh     = {sh[22:0], (hi == T1H)};
          lasthi = hi;
          nb++;
          if (nb == 24) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              check("word_expected", 32'(exp_q.size()), 32'd1);
            end else begin
              exp = exp_q.pop_front();
              check("word", 32'(sh), 32'(exp));
            end
          end
        end
        lo++;
      end
      prev = dl;
    end
  endtask

  task automatic send(input logic [23:0] d, input logic l, input int budget);
    int n = 0;
    pix_data  = d;
    pix_last  = l;
    pix_valid = 1'b1;
    while (!pix_ready && n < budget) begin
      tick();
      n++;
    end
    check("send_accept", 32'(pix_ready), 32'd1);
    if (pix_ready) begin
      exp_q.push_back(d);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // Called right after the transfer edge of a single-pixel frame.
  task automatic watch_frame(output int lat, output int hi1, output int per1,
                             output int rises, output int t_end);
    int   t;
    logic prev;
    lat = 0; hi1 = -1; per1 = -1; rises = 0; t_end = -1;
    while (!dl && lat < 100) begin
      tick();
      lat++;
    end
    if (!dl) return;
    rises = 1;
    prev  = 1'b1;
    t     = 0;
    while (busy && t < 20000) begin
      tick();
      t++;
      if (dl && !prev) begin
        rises++;
        if (rises == 2) per1 = t;
      end
      if (!dl && prev && hi1 < 0) hi1 = t;
      prev = dl;
    end
    if (!busy) t_end = t;
  endtask

  initial begin
    int lat, hi1, per1, rises, t_end;
    int r0, n0, u0, t;

    vecs[0] = '{24'h000000, T0H};
    vecs[1] = '{24'hFFFFFF, T1H};
    vecs[2] = '{24'h5AA55A, T0H};
    vecs[3] = '{24'hC33C96, T1H};

    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_last  = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    check("reset_dout", 32'(dout), 32'(INV));
    check("reset_ready", 32'(pix_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    tick();

    // Single MSB-only pixel: 40/22 first bit, then 23 short bits, then the latch.
    n0 = normal_tot;
    send(24'h800000, 1'b1, 10);
    watch_frame(lat, hi1, per1, rises, t_end);
    check("s1_latency", 32'(lat), 32'd2);
    check("s1_first_high", 32'(hi1), 32'(T1H));
    check("s1_first_period", 32'(per1), 32'(BIT));
    check("s1_rises", 32'(rises), 32'd24);
    check("s1_busy_fall", 32'(t_end), 32'(FRAME + LATCH));
    check("s1_normal_periods", 32'(normal_tot - n0), 32'd23);
    check("s1_idle_level", 32'(dout), 32'(INV));
    check("s1_ready", 32'(pix_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      send(vecs[i].data, 1'b1, 10);
      watch_frame(lat, hi1, per1, rises, t_end);
      check("vec_latency", 32'(lat), 32'd2);
      check("vec_first_high", 32'(hi1), 32'(vecs[i].first_hi));
      check("vec_rises", 32'(rises), 32'd24);
      check("vec_busy_fall", 32'(t_end), 32'(FRAME + LATCH));
    end

    // Three pixels streamed back to back.
    r0 = rises_tot; n0 = normal_tot; u0 = und_cnt;
    send(24'h123456, 1'b0, 2000);
    send(24'h89ABCD, 1'b0, 2000);
    send(24'hE01F7E, 1'b1, 2000);
    wait_idle(10000);
    check("stream_rises", 32'(rises_tot - r0), 32'd72);
    check("stream_normal_periods", 32'(normal_tot - n0), 32'd71);
    check("stream_underrun", 32'(und_cnt - u0), 32'd0);

    // Second pixel withheld: underrun, extended low, then resume.
    r0 = rises_tot; n0 = normal_tot; u0 = und_cnt;
    send(24'h3C5A81, 1'b0, 10);
    t = 0;
    while (!underrun && t < 3000) begin
      tick();
      t++;
    end
    check("ur_pulse_seen", 32'(underrun), 32'd1);
    check("ur_busy", 32'(busy), 32'd1);
    repeat (100) tick();
    send(24'h96E10F, 1'b1, 10);
    wait_idle(10000);
    check("ur_count", 32'(und_cnt - u0), 32'd1);
    // 22-cycle normal low, 100 withheld cycles, plus 2 edges of accept-to-rise latency.
    check("ur_low_gap", 32'(odd_lo), 32'(BIT - T1H + 100 + 2));
    check("ur_rises", 32'(rises_tot - r0), 32'd48);
    check("ur_normal_periods", 32'(normal_tot - n0), 32'd46);

    // Reset while dout is high.
    send(24'hFFFFFF, 1'b1, 10);
    t = 0;
    while (!dl && t < 100) begin
      tick();
      t++;
    end
    repeat (10) tick();
    check("rst_pre_high", 32'(dl), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_dout", 32'(dl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd1);
    exp_q.delete();
    send(24'hA5C33C, 1'b1, 10);
    watch_frame(lat, hi1, per1, rises, t_end);
    check("rst_after_latency", 32'(lat), 32'd2);
    check("rst_after_rises", 32'(rises), 32'd24);
    check("rst_after_busy_fall", 32'(t_end), 32'(FRAME + LATCH));

    // Pixel offered during the latch waits for IDLE.
    send(24'h0F0F0F, 1'b1, 10);
    t = 0;
    while (!dl && t < 100) begin
      tick();
      t++;
    end
    t = 0;
    repeat (1500) tick();
    t = 1500;
    check("latch_busy", 32'(busy), 32'd1);
    send(24'hF0F0F0, 1'b1, 10);
    t++;
    check("latch_ready_low", 32'(pix_ready), 32'd0);
    while (!dl && t < 6000) begin
      tick();
      t++;
    end
    // Latch ends FRAME+LATCH after the first rise; one IDLE cycle precedes the load.
    check("latch_next_rise", 32'(t), 32'(FRAME + LATCH + 1));
    tick();
    wait_idle(10000);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ws2811_encoder.md
# ws2811_encoder

Serialises 24-bit pixel words into the WS2811/WS2812 single-wire NRZ waveform. It sits directly downstream of `strand_driver`, which fetches pixels from strand memory and presents them here over a valid/ready handshake. The block double-buffers one pixel so that consecutive pixels go out back-to-back with no gap. It generates the end-of-frame latch (reset) low period.

## Interface
Parameters:
- `T0H_CYCLES`, default 20: high time of a `0` bit, in clk cycles (0.4 µs at 50 MHz).
- `T1H_CYCLES`, default 40: high time of a `1` bit, in clk cycles (0.8 µs).
- `BIT_CYCLES`, default 62: total bit period, in clk cycles (1.24 µs).
- `LATCH_CYCLES`, default 2500: low time after the last pixel of a frame (50 µs).

Parameter constraint: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES. Violating it is an elaboration error.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `pix_data`  in  24  pixel, wire order (first byte on wire in [23:16]), transmitted MSB first.
- `pix_last`  in  1  qualifies `pix_data`: this is the final pixel of the frame.
- `pix_valid`  in  1  upstream has a pixel.
- `pix_ready`  out  1  holding register empty; transfer occurs on `pix_valid & pix_ready`.
- `dout`  out  1  strand data line.
- `busy`  out  1  frame in progress, including the latch period.
- `underrun`  out  1  one-cycle pulse when a mid-frame pixel was not available in time.

## Operation
Storage:
- Holding register `hold_data`/`hold_last`/`hold_valid`.
- `pix_ready` = `!hold_valid`.
- An accepted pixel sets `hold_valid`.

State machine:
- **IDLE**: `dout` = 0. If `hold_valid`, move the hold register into the shift register, clear `hold_valid`, reset the bit counter to 23, and go to **HIGH**.
- **HIGH**: `dout` = 1 for T1H_CYCLES if the current bit is 1, otherwise for T0H_CYCLES. Then go to **LOW**.
- **LOW**: `dout` = 0 for the rest of the bit. The cycle counter runs 0..BIT_CYCLES-1 across HIGH+LOW.
  - At the end of the bit, if the bit counter is greater than 0: decrement it and go to **HIGH**.
  - At the end of the bit 0, if the current pixel is last: go to **LATCH**.
  - Else, if `hold_valid`: load the next pixel the same cycle and go to **HIGH**, with no gap.
  - Else: pulse `underrun` and go to **WAIT**.
- **WAIT**: `dout` = 0. Load and go to **HIGH** the first cycle `hold_valid` is set. The strand may latch prematurely; this is accepted.
- **LATCH**: `dout` = 0 for LATCH_CYCLES, then go to **IDLE**. Pixels may be accepted into the hold register during LATCH but are not started until IDLE.

Other rules:
- `busy` = 1 in every state except IDLE.
- A simultaneous load from the hold register and a new upstream accept in the same cycle is legal. The register is refilled.
- Counters are sized with `$clog2` of the largest parameter. They never wrap within a legal configuration.

## Timing
- Reset values: `dout` = 0, `pix_ready` = 1, `busy` = 0, `underrun` = 0. State is IDLE and the hold register is cleared.
- Reset mid-frame takes effect at the next edge: `dout` drops to 0 and any partial pixel is discarded.
- Latency: a pixel accepted at edge N in IDLE moves to shift at edge N+1; `dout` rises at N+2.
- A pixel occupies exactly 24 × BIT_CYCLES cycles on `dout`.
- `pix_ready` rises on the cycle after the hold register is loaded into shift, so upstream has ≥ 24 × BIT_CYCLES − 1 cycles to supply the next pixel.
- `underrun` is high for exactly one cycle, concurrent with entry into WAIT.

## Configuration
- `WS2811_INVERT_EN` defined: `dout` is logically inverted, for inverting level shifters. The reset value and the idle level become 1.
- Undefined: non-inverted polarity as described above.
- Only the output register polarity changes. State, timing and handshake behaviour are identical.

## Test plan
- Reset, then single pixel 24'h800000 with `pix_last`=1:
  - `dout` high 40 cycles, low 22.
  - Then 23 bits each high 20, low 42.
  - Then low 2500 cycles.
  - `busy` falls 1488+2500 cycles after the first `dout` rise.
- Three pixels streamed with `pix_valid` held high (last on the third): 72 contiguous bit periods with no extra low gap; `underrun` never asserts.
- Second pixel withheld until 100 cycles after the first pixel ends: `underrun` pulses once, `dout` stays low 100 cycles, then transmission resumes with the correct bits.
- `rst` asserted mid-bit while `dout` = 1: `dout`=0, `busy`=0 and `pix_ready`=1 on the next cycle; a following pixel transmits normally.
- Pixel offered during LATCH: accepted (`pix_ready` falls), first `dout` rise occurs only after the 2500-cycle latch completes.
- With `WS2811_INVERT_EN` defined, rerun the first scenario: every level on `dout` is the complement of the expected waveform.
